// File: rtl/alu_scalar.sv
// rtl/alu_scalar.sv - registered scalar ALU with NZCV flags, one-cycle latency
module alu_scalar #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   ALUControl,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    localparam int SW = $clog2(N);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    logic [N:0]    sum;
    logic [N-1:0]  diff;
    logic [N-1:0]  prod_lo;
    logic [SW-1:0] sh_amt;
    logic          sh_big;
    logic [N-1:0]  r;
    logic          n_f, z_f, c_f, v_f;

    assign sum     = {1'b0, A} + {1'b0, B};
    assign diff    = A - B;
    assign prod_lo = A * B;
    assign sh_amt  = B[SW-1:0];
    // Any set bit above the in-range shift field means the amount is >= N.
    assign sh_big  = |B[N-1:SW];

    always_comb begin
        r = '0;
        case (ALUControl)
            OP_ADD: r = sum[N-1:0];
            OP_SUB: r = diff;
            OP_MUL: r = prod_lo;
            OP_SLL: r = sh_big ? '0 : (A << sh_amt);
            OP_AND: r = A & B;
            OP_OR:  r = A | B;
            OP_XOR: r = A ^ B;
            OP_SRL: r = sh_big ? '0 : (A >> sh_amt);
            default: r = '0;
        endcase
    end

    always_comb begin
        n_f = r[N-1];
        z_f = (r == '0);
        c_f = 1'b0;
        v_f = 1'b0;
        if (ALUControl == OP_ADD) begin
            c_f = sum[N];
            v_f = (A[N-1] == B[N-1]) && (r[N-1] != A[N-1]);
        end else if (ALUControl == OP_SUB) begin
            v_f = (A[N-1] != B[N-1]) && (r[N-1] != A[N-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            flags  <= 4'b0000;
        end else begin
            result <= r;
            flags  <= {n_f, z_f, c_f, v_f};
        end
    end

endmodule

// File: tb/tb_alu_scalar.sv
// tb/tb_alu_scalar.sv - table-driven self-checking bench for alu_scalar
module tb_alu_scalar;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] result;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t vecs[$];

    alu_scalar #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (a),
        .B          (b),
        .ALUControl (op),
        .result     (result),
        .flags      (flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] exp_r, input logic [3:0] exp_f);
        checks++;
        if (result !== exp_r || flags !== exp_f) begin
            errors++;
            $display("FAIL %s: got result=%h flags=%b, expected result=%h flags=%b",
                     name, result, flags, exp_r, exp_f);
        end
    endtask

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
        op  = 3'b000;

        vecs.push_back('{3'b000, 32'd10,         32'd20,         32'd30,         4'b0000});
        vecs.push_back('{3'b001, 32'd30,         32'd10,         32'd20,         4'b0000});
        vecs.push_back('{3'b001, 32'd10,         32'd20,         32'hFFFFFFF6,   4'b1000});
        vecs.push_back('{3'b010, 32'd4,          32'd5,          32'd20,         4'b0000});
        vecs.push_back('{3'b011, 32'd1,          32'd2,          32'd4,          4'b0000});
        vecs.push_back('{3'b111, 32'd4,          32'd1,          32'd2,          4'b0000});
        vecs.push_back('{3'b000, 32'd1,          32'hFFFFFFFF,   32'd0,          4'b0110});
        vecs.push_back('{3'b000, 32'h7FFFFFFF,   32'd1,          32'h80000000,   4'b1001});
        vecs.push_back('{3'b011, 32'd1,          32'd32,         32'd0,          4'b0100});
        vecs.push_back('{3'b111, 32'hFFFFFFFF,   32'd32,         32'd0,          4'b0100});
        vecs.push_back('{3'b100, 32'hF0,         32'h0F,         32'd0,          4'b0100});
        vecs.push_back('{3'b101, 32'hF0,         32'h0F,         32'hFF,         4'b0000});
        vecs.push_back('{3'b110, 32'hFFFF0000,   32'h0F0F0F0F,   32'hF0F00F0F,   4'b1000});
        vecs.push_back('{3'b011, 32'hDEADBEEF,   32'd0,          32'hDEADBEEF,   4'b1000});
        vecs.push_back('{3'b111, 32'hDEADBEEF,   32'd0,          32'hDEADBEEF,   4'b1000});
        vecs.push_back('{3'b111, 32'hFFFFFFFF,   32'h80000001,   32'd0,          4'b0100});
        vecs.push_back('{3'b011, 32'hFFFFFFFF,   32'h00000021,   32'd0,          4'b0100});
        vecs.push_back('{3'b010, 32'h00010000,   32'h00010000,   32'd0,          4'b0100});
        vecs.push_back('{3'b010, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE,   4'b1000});
        vecs.push_back('{3'b001, 32'h80000000,   32'd1,          32'h7FFFFFFF,   4'b0001});
        vecs.push_back('{3'b001, 32'd5,          32'd3,          32'd2,          4'b0000});
        vecs.push_back('{3'b001, 32'd10,         32'd10,         32'd0,          4'b0100});
        vecs.push_back('{3'b000, 32'h80000000,   32'h80000000,   32'd0,          4'b0111});
        vecs.push_back('{3'b011, 32'd1,          32'd31,         32'h80000000,   4'b1000});
        vecs.push_back('{3'b111, 32'h80000000,   32'd31,         32'd1,          4'b0000});
        vecs.push_back('{3'b100, 32'hFFFFFFFF,   32'h80000000,   32'h80000000,   4'b1000});

        // Reset state, including across a clock edge with rst held.
        #2;
        check("reset_async", 32'd0, 4'b0000);
        @(posedge clk);
        #1;
        check("reset_held", 32'd0, 4'b0000);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            op = vecs[i].op;
            a  = vecs[i].a;
            b  = vecs[i].b;
            #1;
            if (i > 0)
                check($sformatf("latency_hold_%0d", i), vecs[i-1].r, vecs[i-1].f);
            @(posedge clk);
            #1;
            check($sformatf("vec_%0d", i), vecs[i].r, vecs[i].f);
        end

        // Asynchronous reset mid-stream while outputs are nonzero.
        @(negedge clk);
        op = 3'b000; a = 32'h7FFFFFFF; b = 32'd1;
        @(posedge clk);
        #1;
        check("pre_rst_nonzero", 32'h80000000, 4'b1001);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_stream", 32'd0, 4'b0000);
        op = 3'b001; a = 32'd30; b = 32'd10;
        @(posedge clk);
        #1;
        check("rst_mid_held", 32'd0, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_released_pre_edge", 32'd0, 4'b0000);
        @(posedge clk);
        #1;
        check("first_edge_after_rst", 32'd20, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
